// File: rtl/ahb_mtx_pkg.sv
// Shared AHB encodings and helpers for the bus-matrix output stage.
package ahb_mtx_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_e;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Number of beats the grant is held for; undefined-length bursts count as 1.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    case (hburst)
      HB_WRAP4,  HB_INCR4:  burst_len = 5'd4;
      HB_WRAP8,  HB_INCR8:  burst_len = 5'd8;
      HB_WRAP16, HB_INCR16: burst_len = 5'd16;
      default:              burst_len = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_mtx_arb_n.sv
// Address-phase arbiter: picks the owning port, holding it across
// fixed-length bursts and locked sequences.
module ahb_mtx_arb_n
  import ahb_mtx_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ARB_MODE  = ARB_FIXED,
  parameter int unsigned PW        = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_hready,
  input  logic                 i_hsel,
  input  logic [1:0]           i_htrans,
  input  logic [2:0]           i_hburst,
  input  logic                 i_hmastlock,
  input  logic                 i_hsel_lock,
  output logic [PW-1:0]        o_addr_port,
  output logic                 o_no_port
);

  logic [PW-1:0] r_addr_port;
  logic          r_no_port;
  logic [PW-1:0] r_rr_last;
  logic [3:0]    r_beat_cnt;

  logic [3:0]    w_beat_cnt_next;
  logic          w_hold;
  logic [PW-1:0] w_winner;
  logic          w_found;
  int unsigned   v_idx;

  // Remaining-beat count as it will be after the current accepted transfer
  always_comb begin
    w_beat_cnt_next = r_beat_cnt;
    if (i_hsel && (i_htrans == HT_NONSEQ)) begin
      w_beat_cnt_next = 4'(burst_len(i_hburst) - 5'd1);
    end else if (i_hsel && (i_htrans == HT_SEQ) && (r_beat_cnt != '0)) begin
      w_beat_cnt_next = r_beat_cnt - 4'd1;
    end
  end

  assign w_hold = (i_hmastlock & (i_hsel_lock | i_hsel)) | (w_beat_cnt_next != '0);

  // Winner selection: lowest index, or first requester after the last grant
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    v_idx    = 0;
    if (ARB_MODE == ARB_RR) begin
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
        v_idx = (32'(r_rr_last) + k) % NUM_PORTS;
        if (!w_found && i_req[v_idx]) begin
          w_winner = PW'(v_idx);
          w_found  = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = NUM_PORTS; i > 0; i--) begin
        if (i_req[i-1]) w_winner = PW'(i - 1);
      end
    end
  end

  // Grant and burst state advance only on accepted (HREADY high) edges
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr_port <= '0;
      r_no_port   <= 1'b1;
      r_rr_last   <= PW'(NUM_PORTS - 1);
      r_beat_cnt  <= '0;
    end else if (i_hready) begin
      r_beat_cnt <= w_beat_cnt_next;
      if (!w_hold) begin
        if (|i_req) begin
          r_addr_port <= w_winner;
          r_no_port   <= 1'b0;
          if (ARB_MODE == ARB_RR) r_rr_last <= w_winner;
        end else begin
          r_no_port <= 1'b1;
        end
      end
    end
  end

  assign o_addr_port = r_addr_port;
  assign o_no_port   = r_no_port;

endmodule

// File: rtl/ahb_mtx_out_stg_n.sv
// Bus-matrix output stage: routes one of NUM_PORTS input stages onto a
// shared AHB slave port, with address and data-phase multiplexing.
module ahb_mtx_out_stg_n
  import ahb_mtx_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned ARB_MODE  = ARB_FIXED,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned UW        = 32
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [NUM_PORTS-1:0]    sel_op,
  input  logic [NUM_PORTS-1:0]    held_tran_op,
  input  logic [NUM_PORTS*AW-1:0] addr_op,
  input  logic [NUM_PORTS*UW-1:0] auser_op,
  input  logic [NUM_PORTS*2-1:0]  trans_op,
  input  logic [NUM_PORTS-1:0]    write_op,
  input  logic [NUM_PORTS*3-1:0]  size_op,
  input  logic [NUM_PORTS*3-1:0]  burst_op,
  input  logic [NUM_PORTS*4-1:0]  prot_op,
  input  logic [NUM_PORTS*4-1:0]  master_op,
  input  logic [NUM_PORTS-1:0]    mastlock_op,
  input  logic [NUM_PORTS*DW-1:0] wdata_op,
  input  logic [NUM_PORTS*UW-1:0] wuser_op,
  input  logic                    HREADYOUTM,
  output logic [NUM_PORTS-1:0]    active_op,
  output logic                    HSELM,
  output logic [AW-1:0]           HADDRM,
  output logic [UW-1:0]           HAUSERM,
  output logic [1:0]              HTRANSM,
  output logic                    HWRITEM,
  output logic [2:0]              HSIZEM,
  output logic [2:0]              HBURSTM,
  output logic [3:0]              HPROTM,
  output logic [3:0]              HMASTERM,
  output logic                    HMASTLOCKM,
  output logic [DW-1:0]           HWDATAM,
  output logic [UW-1:0]           HWUSERM,
  output logic                    HREADYMUXM
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PW-1:0] w_addr_port;
  logic          w_no_port;
  logic          r_hsel_lock;
  logic [PW-1:0] r_data_port;
  logic          r_slave_sel;

  logic          w_sel, w_write, w_lock;
  logic [AW-1:0] w_addr;
  logic [UW-1:0] w_auser, w_wuser;
  logic [1:0]    w_trans;
  logic [2:0]    w_size, w_burst;
  logic [3:0]    w_prot, w_master;
  logic [DW-1:0] w_wdata;

  ahb_mtx_arb_n #(
    .NUM_PORTS (NUM_PORTS),
    .ARB_MODE  (ARB_MODE),
    .PW        (PW)
  ) u_arb (
    .i_clk       (HCLK),
    .i_rst_n     (HRESETn),
    .i_req       (sel_op & held_tran_op),
    .i_hready    (HREADYMUXM),
    .i_hsel      (HSELM),
    .i_htrans    (HTRANSM),
    .i_hburst    (HBURSTM),
    .i_hmastlock (HMASTLOCKM),
    .i_hsel_lock (r_hsel_lock),
    .o_addr_port (w_addr_port),
    .o_no_port   (w_no_port)
  );

  // Address/control mux by owning port; unreachable indices go to X
  always_comb begin
    w_sel = 1'bx; w_addr = 'x; w_auser = 'x; w_trans = 'x; w_write = 1'bx;
    w_size = 'x; w_burst = 'x; w_prot = 'x; w_master = 'x; w_lock = 1'bx;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (w_addr_port == PW'(i)) begin
        w_sel    = sel_op[i];
        w_addr   = addr_op[i*AW +: AW];
        w_auser  = auser_op[i*UW +: UW];
        w_trans  = trans_op[i*2 +: 2];
        w_write  = write_op[i];
        w_size   = size_op[i*3 +: 3];
        w_burst  = burst_op[i*3 +: 3];
        w_prot   = prot_op[i*4 +: 4];
        w_master = master_op[i*4 +: 4];
        w_lock   = mastlock_op[i];
      end
    end
  end

  // Data-phase mux by the port that owned the previous address phase
  always_comb begin
    w_wdata = 'x;
    w_wuser = 'x;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (r_data_port == PW'(i)) begin
        w_wdata = wdata_op[i*DW +: DW];
        w_wuser = wuser_op[i*UW +: UW];
      end
    end
  end

  // One-hot ownership flag
  always_comb begin
    active_op = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      active_op[i] = ~w_no_port & (w_addr_port == PW'(i));
    end
  end

  assign HSELM      = w_no_port ? 1'b0 : w_sel;
  assign HADDRM     = w_no_port ? '0   : w_addr;
  assign HAUSERM    = w_no_port ? '0   : w_auser;
  assign HTRANSM    = w_no_port ? '0   : w_trans;
  assign HWRITEM    = w_no_port ? 1'b0 : w_write;
  assign HSIZEM     = w_no_port ? '0   : w_size;
  assign HBURSTM    = w_no_port ? '0   : w_burst;
  assign HPROTM     = w_no_port ? '0   : w_prot;
  assign HMASTERM   = w_no_port ? '0   : w_master;
  assign HMASTLOCKM = w_no_port ? 1'b0 : w_lock;
  assign HWDATAM    = w_wdata;
  assign HWUSERM    = w_wuser;
  assign HREADYMUXM = r_slave_sel ? HREADYOUTM : 1'b1;

  // Lock tracking survives HSEL dropping; data-phase owner follows address phase
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hsel_lock <= 1'b0;
      r_data_port <= '0;
      r_slave_sel <= 1'b0;
    end else if (HREADYMUXM) begin
      r_data_port <= w_addr_port;
      r_slave_sel <= HSELM;
      if (!HMASTLOCKM) begin
        r_hsel_lock <= 1'b0;
      end else if (HSELM && HTRANSM[1]) begin
        r_hsel_lock <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_mtx_out_stg_n.sv
// Directed bench for the output stage: a fixed-priority and a round-robin
// instance share the same port stimulus.
module tb_ahb_mtx_out_stg_n;
  import ahb_mtx_pkg::*;

  localparam int unsigned N = 4;

  logic           HCLK, HRESETn, HREADYOUTM;
  logic [N-1:0]   sel_op, held_tran_op, write_op, mastlock_op;
  logic [N*32-1:0] addr_op, auser_op, wdata_op, wuser_op;
  logic [N*2-1:0] trans_op;
  logic [N*3-1:0] size_op, burst_op;
  logic [N*4-1:0] prot_op, master_op;

  logic [N-1:0] f_active, r_active;
  logic f_HSELM, f_HWRITEM, f_HMASTLOCKM, f_HREADYMUXM;
  logic r_HSELM, r_HWRITEM, r_HMASTLOCKM, r_HREADYMUXM;
  logic [31:0] f_HADDRM, f_HAUSERM, f_HWDATAM, f_HWUSERM;
  logic [31:0] r_HADDRM, r_HAUSERM, r_HWDATAM, r_HWUSERM;
  logic [1:0] f_HTRANSM, r_HTRANSM;
  logic [2:0] f_HSIZEM, f_HBURSTM, r_HSIZEM, r_HBURSTM;
  logic [3:0] f_HPROTM, f_HMASTERM, r_HPROTM, r_HMASTERM;

  int n_pass = 0;
  int n_total = 0;

  logic [1:0] burst_seq [9] = '{HT_NONSEQ, HT_SEQ, HT_BUSY, HT_SEQ, HT_SEQ,
                                HT_SEQ, HT_SEQ, HT_SEQ, HT_SEQ};

  ahb_mtx_out_stg_n #(.NUM_PORTS(N), .ARB_MODE(ARB_FIXED), .AW(32), .DW(32), .UW(32)) u_fix (
    .HCLK(HCLK), .HRESETn(HRESETn), .sel_op(sel_op), .held_tran_op(held_tran_op),
    .addr_op(addr_op), .auser_op(auser_op), .trans_op(trans_op), .write_op(write_op),
    .size_op(size_op), .burst_op(burst_op), .prot_op(prot_op), .master_op(master_op),
    .mastlock_op(mastlock_op), .wdata_op(wdata_op), .wuser_op(wuser_op),
    .HREADYOUTM(HREADYOUTM), .active_op(f_active), .HSELM(f_HSELM), .HADDRM(f_HADDRM),
    .HAUSERM(f_HAUSERM), .HTRANSM(f_HTRANSM), .HWRITEM(f_HWRITEM), .HSIZEM(f_HSIZEM),
    .HBURSTM(f_HBURSTM), .HPROTM(f_HPROTM), .HMASTERM(f_HMASTERM),
    .HMASTLOCKM(f_HMASTLOCKM), .HWDATAM(f_HWDATAM), .HWUSERM(f_HWUSERM),
    .HREADYMUXM(f_HREADYMUXM)
  );

  ahb_mtx_out_stg_n #(.NUM_PORTS(N), .ARB_MODE(ARB_RR), .AW(32), .DW(32), .UW(32)) u_rr (
    .HCLK(HCLK), .HRESETn(HRESETn), .sel_op(sel_op), .held_tran_op(held_tran_op),
    .addr_op(addr_op), .auser_op(auser_op), .trans_op(trans_op), .write_op(write_op),
    .size_op(size_op), .burst_op(burst_op), .prot_op(prot_op), .master_op(master_op),
    .mastlock_op(mastlock_op), .wdata_op(wdata_op), .wuser_op(wuser_op),
    .HREADYOUTM(HREADYOUTM), .active_op(r_active), .HSELM(r_HSELM), .HADDRM(r_HADDRM),
    .HAUSERM(r_HAUSERM), .HTRANSM(r_HTRANSM), .HWRITEM(r_HWRITEM), .HSIZEM(r_HSIZEM),
    .HBURSTM(r_HBURSTM), .HPROTM(r_HPROTM), .HMASTERM(r_HMASTERM),
    .HMASTLOCKM(r_HMASTLOCKM), .HWDATAM(r_HWDATAM), .HWUSERM(r_HWUSERM),
    .HREADYMUXM(r_HREADYMUXM)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_port(input int p, input logic rq, input logic [1:0] tr,
                          input logic [2:0] bu, input logic lk);
    sel_op[p] = rq;
    held_tran_op[p] = rq;
    trans_op[p*2 +: 2] = tr;
    burst_op[p*3 +: 3] = bu;
    mastlock_op[p] = lk;
  endtask

  task automatic clear_all();
    for (int p = 0; p < int'(N); p++) set_port(p, 1'b0, HT_IDLE, HB_SINGLE, 1'b0);
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    #2;
    HRESETn = 1'b1;
  endtask

  initial begin
    HRESETn = 1'b0;
    HREADYOUTM = 1'b1;
    sel_op = '0; held_tran_op = '0; write_op = '0; mastlock_op = '0;
    trans_op = '0; size_op = '0; burst_op = '0; prot_op = '0; master_op = '0;
    addr_op = '0; auser_op = '0; wdata_op = '0; wuser_op = '0;
    for (int p = 0; p < int'(N); p++) begin
      addr_op[p*32 +: 32]  = 32'hA000_0000 + 32'(p * 256);
      auser_op[p*32 +: 32] = 32'hB000_0000 + 32'(p);
      wdata_op[p*32 +: 32] = 32'hD000_0000 + 32'(p);
      wuser_op[p*32 +: 32] = 32'hE000_0000 + 32'(p);
      size_op[p*3 +: 3]    = 3'd2;
      prot_op[p*4 +: 4]    = 4'h3;
      master_op[p*4 +: 4]  = 4'(p + 8);
      write_op[p]          = p[0];
    end
    step();
    step();

    // Reset state
    chk("rst_f_ctrl_zero", 32'(|{f_HSELM, f_HADDRM, f_HAUSERM, f_HTRANSM, f_HWRITEM, f_HSIZEM,
        f_HBURSTM, f_HPROTM, f_HMASTERM, f_HMASTLOCKM, f_active}), 32'd0);
    chk("rst_r_ctrl_zero", 32'(|{r_HSELM, r_HADDRM, r_HAUSERM, r_HTRANSM, r_HWRITEM, r_HSIZEM,
        r_HBURSTM, r_HPROTM, r_HMASTERM, r_HMASTLOCKM, r_active}), 32'd0);
    chk("rst_f_hready", 32'(f_HREADYMUXM), 32'd1);
    chk("rst_r_hready", 32'(r_HREADYMUXM), 32'd1);
    chk("rst_f_wdata", f_HWDATAM, 32'hD000_0000);
    chk("rst_f_wuser", f_HWUSERM, 32'hE000_0000);
    chk("rst_r_wdata", r_HWDATAM, 32'hD000_0000);
    chk("rst_r_wuser", r_HWUSERM, 32'hE000_0000);

    // First grant appears one cycle after the request
    HRESETn = 1'b1;
    set_port(2, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
    #1;
    chk("req2_pre_hsel", 32'(f_HSELM), 32'd0);
    step();
    chk("req2_f_active", 32'(f_active), 32'b0100);
    chk("req2_r_active", 32'(r_active), 32'b0100);
    chk("req2_hsel", 32'(f_HSELM), 32'd1);
    chk("req2_haddr", f_HADDRM, 32'hA000_0200);
    chk("req2_hauser", f_HAUSERM, 32'hB000_0002);
    chk("req2_htrans", 32'(f_HTRANSM), 32'd2);
    chk("req2_hmaster", 32'(f_HMASTERM), 32'd10);
    chk("req2_hsize", 32'(f_HSIZEM), 32'd2);
    chk("req2_hprot", 32'(f_HPROTM), 32'd3);
    chk("req2_hwrite", 32'(f_HWRITEM), 32'd0);
    step();
    chk("req2_b2b_active", 32'(f_active), 32'b0100);
    chk("req2_wdata", f_HWDATAM, 32'hD000_0002);
    chk("req2_hreadymux", 32'(f_HREADYMUXM), 32'd1);
    set_port(2, 1'b0, HT_IDLE, HB_SINGLE, 1'b0);
    step();
    chk("idle_f_active", 32'(f_active), 32'd0);
    chk("idle_r_active", 32'(r_active), 32'd0);
    chk("idle_hsel", 32'(f_HSELM), 32'd0);

    // Ports 1 and 3 compete: fixed keeps 1, round-robin (last=2) alternates 3,1
    set_port(1, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
    set_port(3, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fix13_active", 32'(f_active), 32'b0010);
      chk("rr13_active", 32'(r_active), (k % 2 == 0) ? 32'b1000 : 32'b0010);
    end
    clear_all();
    step();

    // All four request: round-robin 0,1,2,3,...; fixed always 0
    do_reset();
    for (int p = 0; p < int'(N); p++) set_port(p, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr4_active", 32'(r_active), 32'(1) << (k % 4));
      chk("fix4_active", 32'(f_active), 32'b0001);
    end
    clear_all();
    step();

    // INCR8 with one BUSY on port 0 while port 1 waits
    do_reset();
    set_port(1, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
    set_port(0, 1'b1, HT_NONSEQ, HB_INCR8, 1'b0);
    step();
    chk("incr8_grant_f", 32'(f_active), 32'b0001);
    chk("incr8_grant_r", 32'(r_active), 32'b0001);
    for (int j = 0; j < 9; j++) begin
      trans_op[1:0] = burst_seq[j];
      if (j == 8) held_tran_op[0] = 1'b0;
      step();
      if (j == 2) chk("incr8_busy_htrans", 32'(f_HTRANSM), 32'(HT_BUSY));
      if (j < 8) begin
        chk("incr8_hold_f", 32'(f_active), 32'b0001);
        chk("incr8_hold_r", 32'(r_active), 32'b0001);
      end else begin
        chk("incr8_handover_f", 32'(f_active), 32'b0010);
        chk("incr8_handover_r", 32'(r_active), 32'b0010);
      end
    end
    clear_all();
    step();

    // Locked sequence on port 2 survives an HSEL gap
    do_reset();
    set_port(2, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b1);
    step();
    chk("lock_grant", 32'(f_active), 32'b0100);
    chk("lock_mastlock", 32'(f_HMASTLOCKM), 32'd1);
    set_port(0, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
    step();
    chk("lock_l1_f", 32'(f_active), 32'b0100);
    set_port(2, 1'b0, HT_IDLE, HB_SINGLE, 1'b1);
    step();
    chk("lock_gap1_f", 32'(f_active), 32'b0100);
    chk("lock_gap1_hsel", 32'(f_HSELM), 32'd0);
    step();
    chk("lock_gap2_f", 32'(f_active), 32'b0100);
    chk("lock_gap2_r", 32'(r_active), 32'b0100);
    set_port(2, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b1);
    step();
    chk("lock_l4_f", 32'(f_active), 32'b0100);
    set_port(2, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
    step();
    chk("unlock_f", 32'(f_active), 32'b0001);
    chk("unlock_r", 32'(r_active), 32'b0001);
    clear_all();
    step();

    // Port 1 write with 3 wait states, then reset during the wait
    do_reset();
    set_port(1, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
    step();
    chk("ws_grant", 32'(f_active), 32'b0010);
    chk("ws_hwrite", 32'(f_HWRITEM), 32'd1);
    step();
    HREADYOUTM = 1'b0;
    set_port(1, 1'b0, HT_IDLE, HB_SINGLE, 1'b0);
    set_port(0, 1'b1, HT_NONSEQ, HB_SINGLE, 1'b0);
    #1;
    for (int w = 0; w < 3; w++) begin
      if (w > 0) step();
      chk("ws_f_hready", 32'(f_HREADYMUXM), 32'd0);
      chk("ws_r_hready", 32'(r_HREADYMUXM), 32'd0);
      chk("ws_wdata", f_HWDATAM, 32'hD000_0001);
      chk("ws_f_frozen", 32'(f_active), 32'b0010);
      chk("ws_r_frozen", 32'(r_active), 32'b0010);
    end
    HRESETn = 1'b0;
    #1;
    chk("ws_rst_f_hready", 32'(f_HREADYMUXM), 32'd1);
    chk("ws_rst_r_hready", 32'(r_HREADYMUXM), 32'd1);
    chk("ws_rst_f_active", 32'(f_active), 32'd0);
    chk("ws_rst_r_active", 32'(r_active), 32'd0);
    chk("ws_rst_hsel", 32'(f_HSELM), 32'd0);
    chk("ws_rst_wdata", f_HWDATAM, 32'hD000_0000);
    HRESETn = 1'b1;
    HREADYOUTM = 1'b1;
    clear_all();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ahb_mtx_out_stg_n.md
Name: ahb_mtx_out_stg_n

Overview:
Parametrised successor of the bus-matrix output stage. It routes one of NUM_PORTS input-stage ports onto a shared AHB slave port. It adds a selectable arbitration mode (fixed-priority or round-robin), burst-atomic grant hold for fixed-length bursts, and locked-sequence hold. It sits between the matrix input stages and one slave, one instance per slave.

Parameters:
NUM_PORTS, 2, number of input-stage ports (2..16); PW = clog2(NUM_PORTS), minimum 1
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
AW, 32, address width
DW, 32, write-data width
UW, 32, HAUSER/HWUSER width

Ports:
HCLK  in  1  AHB clock
HRESETn  in  1  asynchronous active-low reset
sel_op  in  NUM_PORTS  per-port HSEL
held_tran_op  in  NUM_PORTS  per-port held-transfer flag
addr_op  in  NUM_PORTS*AW  per-port HADDR, port i at [i*AW +: AW]
auser_op  in  NUM_PORTS*UW  per-port HAUSER
trans_op  in  NUM_PORTS*2  per-port HTRANS
write_op  in  NUM_PORTS  per-port HWRITE
size_op / burst_op  in  NUM_PORTS*3 each  per-port HSIZE / HBURST
prot_op / master_op  in  NUM_PORTS*4 each  per-port HPROT / HMASTER
mastlock_op  in  NUM_PORTS  per-port HMASTLOCK
wdata_op  in  NUM_PORTS*DW  per-port HWDATA
wuser_op  in  NUM_PORTS*UW  per-port HWUSER
HREADYOUTM  in  1  slave HREADYOUT
active_op  out  NUM_PORTS  one-hot: port currently owns the address phase
HSELM, HADDRM[AW], HAUSERM[UW], HTRANSM[2], HWRITEM, HSIZEM[3], HBURSTM[3], HPROTM[4], HMASTERM[4], HMASTLOCKM  out  slave address/control
HWDATAM[DW], HWUSERM[UW]  out  slave data-phase write data and user data
HREADYMUXM  out  1  slave HREADY

Behaviour:
- Request and grant
  - req[i] = sel_op[i] & held_tran_op[i].
  - Registers: addr_port[PW], no_port, rr_last[PW], beat_cnt[4], hsel_lock, data_port[PW], slave_sel. All are updated only on rising HCLK with HREADYMUXM=1.
  - Reset values: addr_port=0, no_port=1, rr_last=NUM_PORTS-1, beat_cnt=0, hsel_lock=0, data_port=0, slave_sel=0.
- Output values
  - After reset: HSELM=0, HTRANSM=IDLE, all other address/control outputs 0, active_op=0, HREADYMUXM=1, HWDATAM/HWUSERM = port 0 values.
  - Address mux: when no_port=1, all address/control outputs are 0. Otherwise they are driven from port addr_port, combinationally, with zero latency from the port inputs.
  - active_op[addr_port] = ~no_port; all other bits are 0.
- Hold and arbitration
  - hold = hlock_arb | (beat_cnt_next != 0).
  - hlock_arb = HMASTLOCKM & (hsel_lock | HSELM).
  - On an update edge with hold=1, addr_port and no_port are kept.
  - On an update edge with hold=0 and any req: winner granted, no_port=0.
    - Mode 0: lowest index wins.
    - Mode 1: first requesting index after rr_last, modulo NUM_PORTS; rr_last := winner.
  - On an update edge with hold=0 and no req: no_port=1, addr_port kept.
  - The new grant is visible on the outputs the cycle after the edge (one-cycle arbitration latency).
  - A sole requester stays granted every cycle, so back-to-back transfers have no bubble.
- Burst hold (beat_cnt_next)
  - On accepted HSELM & NONSEQ: load len-1, where len = 4/8/16 for WRAP4/INCR4, WRAP8/INCR8, WRAP16/INCR16, and len = 1 for SINGLE and INCR.
  - On accepted SEQ: decrement, saturating at 0.
  - On BUSY or IDLE: hold the value.
  - The counter is reloaded by a new NONSEQ, which covers early burst termination.
- hsel_lock
  - Set on accepted HSELM & HTRANSM[1] & HMASTLOCKM.
  - Cleared when HMASTLOCKM=0.
  - Otherwise kept.
- Data phase
  - data_port := addr_port on each update edge.
  - HWDATAM/HWUSERM are muxed by data_port.
- HREADYMUXM = slave_sel ? HREADYOUTM : 1. slave_sel := HSELM on each update edge.
- Wait states: with HREADYMUXM=0, all registers freeze and the grant cannot change.
- Reset mid-burst or mid-lock: every register returns to its reset value immediately (asynchronous), with no completion of the pending transfer.
- Out-of-range addr_port (non-power-of-2 NUM_PORTS) is unreachable. The mux default drives X for simulation only.

Decomposition:
- Package ahb_mtx_pkg: HTRANS codes (IDLE, BUSY, NONSEQ, SEQ), HBURST codes, burst_len(hburst) function, ARB_FIXED/ARB_RR constants.
- Sub-module ahb_mtx_arb_n: holds req/hold/ARB_MODE logic, addr_port, no_port, rr_last and beat_cnt. The output stage keeps the muxes, hsel_lock, data_port and slave_sel.

Test Plan:
- Reset, then idle -> HSELM=0, HTRANSM=0, HREADYMUXM=1, active_op=0. With req[2] asserted (NUM_PORTS=4): HSELM follows port 2 one cycle later, active_op=4'b0100.
- ARB_MODE=0, ports 1 and 3 request continuously with SINGLE transfers -> port 1 is granted every cycle; port 3 is never granted.
- ARB_MODE=1, all 4 ports request SINGLE continuously -> grant order 0,1,2,3,0,…; each port gets one transfer per 4 accepted cycles.
- Port 0 issues INCR8 with one BUSY cycle while port 1 requests -> port 0 holds for all 8 beats; port 1 is granted on the edge accepting beat 8.
- Port 2 locked sequence with HSEL dropped for 2 cycles mid-lock while port 0 requests -> port 0 is not granted until HMASTLOCK deasserts.
- Slave inserts 3 wait states on a port 1 write -> HREADYMUXM=0 for 3 cycles, HWDATAM = wdata_op port 1 throughout, grant frozen. Asserting HRESETn=0 mid-wait -> HREADYMUXM=1 and no_port=1 immediately.
